// File: rtl/flash_pkg.sv
// Shared constants and state encoding for the SPI flash READ responder.
package flash_pkg;

  localparam logic [7:0] C_OP_READ   = 8'h03;
  localparam int         C_OP_BITS   = 8;
  localparam int         C_ADDR_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous pin, plus a third register
// that yields single-cycle rise and fall strobes of the synchronized level.
module spi_sync_edge (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_responder_flash.sv
// SPI mode-0 device end of a flash READ (0x03) bus: decodes opcode and address,
// streams memory bytes MSB-first with auto-increment and wrap at the array top.
module spi_responder_flash
  import flash_pkg::*;
#(
  parameter int         G_ADDR_WIDTH  = 17,
  parameter logic [7:0] G_READ_OPCODE = C_OP_READ
) (
  input  logic                    i_sys_clk,
  input  logic                    i_reset_n,
  input  logic                    i_spi_clk,
  input  logic                    i_spi_cs_n,
  input  logic                    i_spi_si,
  output logic                    o_spi_so,
  output logic                    o_mem_rd_en,
  output logic [G_ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [7:0]              i_mem_data,
  output logic                    o_busy,
  output logic                    o_cmd_error
);

  // The shift register only needs to hold the implemented address bits, so
  // the ignored upper address bits simply fall off its top.
  localparam int         C_SR_W      = (G_ADDR_WIDTH > C_OP_BITS) ? G_ADDR_WIDTH : C_OP_BITS;
  localparam logic [4:0] C_CMD_LAST  = 5'(C_OP_BITS - 1);
  localparam logic [4:0] C_ADDR_LAST = 5'(C_ADDR_BITS - 1);
  localparam logic [4:0] C_BYTE_LAST = 5'd7;

  logic w_sck_rise;
  logic w_sck_fall;
  logic w_unused_sck_level;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_unused_cs_level;
  logic w_si;
  logic w_unused_si_rise;
  logic w_unused_si_fall;

  logic [C_SR_W-1:0] w_shift_next;

  state_t                  r_state;
  logic [4:0]              r_bit_cnt;
  logic [C_SR_W-2:0]       r_shift_in;
  logic [G_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]              r_buf;
  logic [7:0]              r_shift_out;
  logic                    r_so;
  logic                    r_rd_en;
  logic                    r_rd_vld_p1;
  logic                    r_fetch_req;
  logic [G_ADDR_WIDTH-1:0] r_mem_addr;
  logic                    r_cmd_error;

  spi_sync_edge u_sync_sck (
    .i_clk     (i_sys_clk),
    .i_reset_n (i_reset_n),
    .i_async   (i_spi_clk),
    .o_level   (w_unused_sck_level),
    .o_rise    (w_sck_rise),
    .o_fall    (w_sck_fall)
  );

  spi_sync_edge u_sync_cs (
    .i_clk     (i_sys_clk),
    .i_reset_n (i_reset_n),
    .i_async   (i_spi_cs_n),
    .o_level   (w_unused_cs_level),
    .o_rise    (w_cs_rise),
    .o_fall    (w_cs_fall)
  );

  spi_sync_edge u_sync_si (
    .i_clk     (i_sys_clk),
    .i_reset_n (i_reset_n),
    .i_async   (i_spi_si),
    .o_level   (w_si),
    .o_rise    (w_unused_si_rise),
    .o_fall    (w_unused_si_fall)
  );

  assign w_shift_next = {r_shift_in, w_si};

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift_in  <= '0;
      r_addr      <= '0;
      r_buf       <= '0;
      r_shift_out <= '0;
      r_so        <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_vld_p1 <= 1'b0;
      r_fetch_req <= 1'b0;
      r_mem_addr  <= '0;
      r_cmd_error <= 1'b0;
    end else begin
      r_rd_en     <= 1'b0;
      r_cmd_error <= 1'b0;
      r_rd_vld_p1 <= r_rd_en;
      // Read data lands one cycle after the strobe; drop it once the frame ended.
      if (r_rd_vld_p1 && (r_state == ST_DATA)) begin
        r_buf <= i_mem_data;
      end

      if (w_cs_rise) begin
        r_state     <= ST_IDLE;
        r_so        <= 1'b0;
        r_fetch_req <= 1'b0;
        r_bit_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_cs_fall) begin
              r_state    <= ST_CMD;
              r_bit_cnt  <= '0;
              r_shift_in <= '0;
              r_so       <= 1'b0;
            end
          end

          ST_CMD: begin
            if (w_sck_rise) begin
              r_shift_in <= w_shift_next[C_SR_W-2:0];
              if (r_bit_cnt == C_CMD_LAST) begin
                r_bit_cnt <= '0;
                if (w_shift_next[7:0] == G_READ_OPCODE) begin
                  r_state <= ST_ADDR;
                end else begin
                  r_cmd_error <= 1'b1;
                  r_state     <= ST_IGNORE;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end

          ST_ADDR: begin
            if (w_sck_rise) begin
              r_shift_in <= w_shift_next[C_SR_W-2:0];
              if (r_bit_cnt == C_ADDR_LAST) begin
                r_bit_cnt  <= '0;
                r_addr     <= w_shift_next[G_ADDR_WIDTH-1:0];
                r_mem_addr <= w_shift_next[G_ADDR_WIDTH-1:0];
                r_rd_en    <= 1'b1;
                r_state    <= ST_DATA;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end

          ST_DATA: begin
            // Prefetch the following byte right after the buffer was consumed.
            if (r_fetch_req) begin
              r_fetch_req <= 1'b0;
              r_rd_en     <= 1'b1;
              r_mem_addr  <= r_addr + G_ADDR_WIDTH'(1);
              r_addr      <= r_addr + G_ADDR_WIDTH'(1);
            end
            if (w_sck_fall) begin
              if (r_bit_cnt == 5'd0) begin
                r_so        <= r_buf[7];
                r_shift_out <= {r_buf[6:0], 1'b0};
                r_fetch_req <= 1'b1;
              end else begin
                r_so        <= r_shift_out[7];
                r_shift_out <= {r_shift_out[6:0], 1'b0};
              end
              r_bit_cnt <= (r_bit_cnt == C_BYTE_LAST) ? 5'd0 : r_bit_cnt + 5'd1;
            end
          end

          ST_IGNORE: begin
            r_so <= 1'b0;
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_spi_so    = r_so;
  assign o_mem_rd_en = r_rd_en;
  assign o_mem_addr  = r_mem_addr;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_cmd_error = r_cmd_error;

endmodule
